rom_dl_bridge: RTL

- Sits between the data_io download stream and the two write ports of the SDRAM controller (CPU/sound port and gfx port).
- Captures each ioctl byte strobe into a small FIFO.
- Replays each byte to the SDRAM using toggle req/ack handshakes, so SPI bursts never depend on SDRAM latency.
- Mirrors gfx-region bytes to the gfx port at a rebased address, and raises rom_loaded once the download has fully drained.

---
 rtl/rom_dl_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rom_dl_bridge.sv
// Bridges the ioctl download byte stream into the two SDRAM write ports via a small FIFO.
// Optional macro DL_BRIDGE_CHECKSUM_EN adds dl_checksum, a running sum of bytes written out.
module rom_dl_bridge #(
    parameter int unsigned FIFO_AW  = 2,
    parameter logic [24:0] GFX_BASE = 25'h0E000,
    parameter logic [7:0]  DL_INDEX = 8'd0
) (
    input  logic        clk_sys,
    input  logic        res_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        rom_loaded,
    output logic        overflow
`ifdef DL_BRIDGE_CHECKSUM_EN
    ,
    output logic [15:0] dl_checksum
`endif
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t             state_q, state_d;
    logic               do_latch, do_issue, do_pop, do_push;
    logic               wr_last, dl_last, dl_rise, dl_fall, accept;
    logic               gfx_pend, cur_gfx, got_byte, dl_ended;
    logic [32:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_empty, fifo_full;
    logic [24:0]        head_addr;
    logic [7:0]         head_data;
    logic [23:0]        rebased;

    assign dl_rise    = ioctl_download & ~dl_last;
    assign dl_fall    = ~ioctl_download & dl_last;
    assign accept     = ioctl_wr & ~wr_last & ioctl_download & (ioctl_index == DL_INDEX);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (FIFO_AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
    assign do_push    = accept & (~fifo_full | do_pop);
    assign head_addr  = fifo_mem[rd_ptr][32:8];
    assign head_data  = fifo_mem[rd_ptr][7:0];
    // Only the low 24 bits of the rebased address reach the port.
    assign rebased    = head_addr[23:0] - GFX_BASE[23:0];
    assign port_we    = (state_q != StIdle) | ~fifo_empty;

    always_comb begin
        state_d  = state_q;
        do_latch = 1'b0;
        do_issue = 1'b0;
        do_pop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    do_latch = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                do_issue = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if ((port1_req == port1_ack) && (!gfx_pend || (port2_req == port2_ack))) begin
                    do_pop  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q   <= StIdle;
            port1_req <= 1'b0;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
            port2_req <= 1'b0;
            port2_a   <= '0;
            port2_ds  <= '0;
            port2_d   <= '0;
            gfx_pend  <= 1'b0;
            cur_gfx   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_latch) begin
                port1_a  <= head_addr[23:1];
                port1_ds <= {head_addr[0], ~head_addr[0]};
                port1_d  <= {head_data, head_data};
                port2_a  <= rebased[23:1];
                port2_ds <= {rebased[0], ~rebased[0]};
                port2_d  <= {head_data, head_data};
                cur_gfx  <= (head_addr >= GFX_BASE);
            end
            if (do_issue) begin
                port1_req <= ~port1_req;
                if (cur_gfx) begin
                    port2_req <= ~port2_req;
                    gfx_pend  <= 1'b1;
                end
            end
            if (do_pop) gfx_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!do_push && do_pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            wr_last    <= 1'b0;
            dl_last    <= 1'b0;
            overflow   <= 1'b0;
            got_byte   <= 1'b0;
            dl_ended   <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            wr_last  <= ioctl_wr;
            dl_last  <= ioctl_download;
            got_byte <= (dl_rise ? 1'b0 : got_byte) | accept;
            if (accept && fifo_full && !do_pop) overflow <= 1'b1;
            else if (dl_rise)                   overflow <= 1'b0;
            if (dl_rise)                  dl_ended <= 1'b0;
            else if (dl_fall && got_byte) dl_ended <= 1'b1;
            if (dl_rise) rom_loaded <= 1'b0;
            else if (dl_ended && fifo_empty && state_q == StIdle) rom_loaded <= 1'b1;
        end
    end

`ifdef DL_BRIDGE_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n)      csum_q <= '0;
        else if (dl_rise) csum_q <= '0;
        else if (do_pop)  csum_q <= csum_q + {8'd0, port1_d[7:0]};
    end

    assign dl_checksum = csum_q;
`endif

endmodule
